// File: rtl/lsu_queue.sv
// lsu_queue -- in-order load/store queue in front of the unified cache data port.
//
// Buffers memory ops from dispatch/commit and issues them one at a time over
// the en_ls / in_fifo / finish handshake. Load results are byte-reversed out of
// the cache packing, sign/zero-extended and broadcast with their tag.
//
// Optional feature macro: LSU_MISALIGN_CHK_EN
//   When defined, misaligned halfword/word heads are never issued. They complete
//   locally with out_err_o=1, and the out_err_o port is added.
//
// Ports
//   clk_i, rst_i            clock, async active-high reset
//   rdy_i                   global ready; low freezes the queue and aborts cache traffic
//   in_valid_i/in_ready_o   enqueue handshake
//   in_store_i, in_funct3_i, in_addr_i, in_data_i, in_tag_i   op fields
//   flush_i                 mispredict flush
//   en_ls_o, ls_oper_o, ls_addr_o, ls_data_o, ls_size_o       cache request
//   in_fifo_i               cache accepted request (pulse)
//   finish_i, ls_data_out_i cache load completion and data
//   out_valid_o, out_tag_o, out_data_o (, out_err_o)          result broadcast
//   count_o                 occupied entries
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no cache request open; issue or locally complete the head
// REQ   | request presented, waiting for in_fifo
// WAIT  | load accepted, waiting for finish
module lsu_queue #(
   parameter int DEPTH   = 8,
   parameter int DEPTH_W = 3,
   parameter int TAG_W   = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               rdy_i,
   input  logic               in_valid_i,
   output logic               in_ready_o,
   input  logic               in_store_i,
   input  logic [2:0]         in_funct3_i,
   input  logic [31:0]        in_addr_i,
   input  logic [31:0]        in_data_i,
   input  logic [TAG_W-1:0]   in_tag_i,
   input  logic               flush_i,
   output logic               en_ls_o,
   output logic               ls_oper_o,
   output logic [31:0]        ls_addr_o,
   output logic [31:0]        ls_data_o,
   output logic [7:0]         ls_size_o,
   input  logic               in_fifo_i,
   input  logic               finish_i,
   input  logic [31:0]        ls_data_out_i,
   output logic               out_valid_o,
   output logic [TAG_W-1:0]   out_tag_o,
   output logic [31:0]        out_data_o,
`ifdef LSU_MISALIGN_CHK_EN
   output logic               out_err_o,
`endif
   output logic [DEPTH_W:0]   count_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

   localparam logic [DEPTH_W:0]   CNT_FULL = (DEPTH_W+1)'(DEPTH);
   localparam logic [DEPTH_W:0]   CNT_ONE  = (DEPTH_W+1)'(1);
   localparam logic [DEPTH_W-1:0] PTR_ONE  = DEPTH_W'(1);

   logic             mem_store [DEPTH];
   logic [2:0]       mem_funct3[DEPTH];
   logic [31:0]      mem_addr  [DEPTH];
   logic [31:0]      mem_data  [DEPTH];
   logic [TAG_W-1:0] mem_tag   [DEPTH];

   state_t             state_q, state_d;
   logic [DEPTH_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [DEPTH_W:0]   count_q, count_d;
   logic               drop_q, drop_d;
   logic               en_ls_q, en_ls_d;
   logic               ls_oper_q, ls_oper_d;
   logic [31:0]        ls_addr_q, ls_addr_d;
   logic [31:0]        ls_data_q, ls_data_d;
   logic [7:0]         ls_size_q, ls_size_d;
   logic               out_valid_q, out_valid_d;
   logic [TAG_W-1:0]   out_tag_q, out_tag_d;
   logic [31:0]        out_data_q, out_data_d;
`ifdef LSU_MISALIGN_CHK_EN
   logic               out_err_q, out_err_d;
   logic               h_misalign;
`endif

   logic             push, pop, empty, h_local;
   logic             h_store;
   logic [2:0]       h_funct3;
   logic [31:0]      h_addr, h_data;
   logic [TAG_W-1:0] h_tag;
   logic [15:0]      v16;
   logic [31:0]      ld_ext;
   logic [7:0]       h_size;

   assign empty      = (count_q == '0);
   assign in_ready_o = (count_q != CNT_FULL);
   assign push       = in_valid_i & in_ready_o & rdy_i & ~flush_i;

   assign h_store  = mem_store[head_q];
   assign h_funct3 = mem_funct3[head_q];
   assign h_addr   = mem_addr[head_q];
   assign h_data   = mem_data[head_q];
   assign h_tag    = mem_tag[head_q];

`ifdef LSU_MISALIGN_CHK_EN
   assign h_misalign = ((h_funct3[1:0] == 2'b01) && h_addr[0]) ||
                       ((h_funct3[1:0] == 2'b10) && (h_addr[1:0] != 2'b00));
   assign h_local    = (h_addr == 32'd0) || h_misalign;
`else
   assign h_local    = (h_addr == 32'd0);
`endif

   always_comb begin
      case (h_funct3[1:0])
         2'b00:   h_size = 8'd1;
         2'b01:   h_size = 8'd2;
         default: h_size = 8'd4;
      endcase
   end

   // Cache packs the lowest-address byte most-significant inside the low
   // size*8 bits, so undo that before extending.
   always_comb begin
      v16    = {ls_data_out_i[7:0], ls_data_out_i[15:8]};
      ld_ext = '0;
      case (h_funct3[1:0])
         2'b00:   ld_ext = {{24{~h_funct3[2] & ls_data_out_i[7]}}, ls_data_out_i[7:0]};
         2'b01:   ld_ext = {{16{~h_funct3[2] & v16[15]}}, v16};
         default: ld_ext = {ls_data_out_i[7:0], ls_data_out_i[15:8],
                            ls_data_out_i[23:16], ls_data_out_i[31:24]};
      endcase
   end

   always_comb begin
      state_d     = state_q;
      drop_d      = drop_q;
      en_ls_d     = en_ls_q;
      ls_oper_d   = ls_oper_q;
      ls_addr_d   = ls_addr_q;
      ls_data_d   = ls_data_q;
      ls_size_d   = ls_size_q;
      out_valid_d = 1'b0;
      out_tag_d   = out_tag_q;
      out_data_d  = out_data_q;
`ifdef LSU_MISALIGN_CHK_EN
      out_err_d   = out_err_q;
`endif
      pop         = 1'b0;

      if (!rdy_i) begin
         // Cache drops in-flight state; the head stays queued and re-issues.
         if (state_q != IDLE) begin
            state_d = IDLE;
            en_ls_d = 1'b0;
            drop_d  = 1'b0;
         end
      end else if (flush_i) begin
         case (state_q)
            REQ: begin
               en_ls_d = 1'b0;
               // A load accepted on the flush edge still owes a finish; swallow it.
               if (in_fifo_i && !ls_oper_q) begin
                  state_d = WAIT;
                  drop_d  = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
            WAIT: begin
               if (finish_i) begin
                  state_d = IDLE;
                  drop_d  = 1'b0;
               end else begin
                  drop_d  = 1'b1;
               end
            end
            default: ;
         endcase
      end else begin
         case (state_q)
            IDLE: begin
               if (!empty) begin
                  if (h_local) begin
                     pop = 1'b1;
`ifdef LSU_MISALIGN_CHK_EN
                     if (h_misalign) begin
                        out_valid_d = 1'b1;
                        out_err_d   = 1'b1;
                        out_tag_d   = h_tag;
                        out_data_d  = '0;
                     end else
`endif
                     if (!h_store) begin
                        out_valid_d = 1'b1;
                        out_tag_d   = h_tag;
                        out_data_d  = '0;
`ifdef LSU_MISALIGN_CHK_EN
                        out_err_d   = 1'b0;
`endif
                     end
                  end else begin
                     en_ls_d   = 1'b1;
                     ls_oper_d = h_store;
                     ls_addr_d = h_addr;
                     ls_data_d = h_data;
                     ls_size_d = h_size;
                     state_d   = REQ;
                  end
               end
            end
            REQ: begin
               if (in_fifo_i) begin
                  en_ls_d = 1'b0;
                  if (ls_oper_q) begin
                     pop     = 1'b1;
                     state_d = IDLE;
                  end else begin
                     state_d = WAIT;
                  end
               end
            end
            WAIT: begin
               if (finish_i) begin
                  state_d = IDLE;
                  if (drop_q) begin
                     drop_d = 1'b0;
                  end else begin
                     pop         = 1'b1;
                     out_valid_d = 1'b1;
                     out_tag_d   = h_tag;
                     out_data_d  = ld_ext;
`ifdef LSU_MISALIGN_CHK_EN
                     out_err_d   = 1'b0;
`endif
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush_i) begin
         head_d  = tail_q;
         count_d = '0;
      end else begin
         if (push) tail_d = tail_q + PTR_ONE;
         if (pop)  head_d = head_q + PTR_ONE;
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_store[tail_q]  <= in_store_i;
         mem_funct3[tail_q] <= in_funct3_i;
         mem_addr[tail_q]   <= in_addr_i;
         mem_data[tail_q]   <= in_data_i;
         mem_tag[tail_q]    <= in_tag_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         drop_q      <= 1'b0;
         en_ls_q     <= 1'b0;
         ls_oper_q   <= 1'b0;
         ls_addr_q   <= '0;
         ls_data_q   <= '0;
         ls_size_q   <= '0;
         out_valid_q <= 1'b0;
         out_tag_q   <= '0;
         out_data_q  <= '0;
`ifdef LSU_MISALIGN_CHK_EN
         out_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         drop_q      <= drop_d;
         en_ls_q     <= en_ls_d;
         ls_oper_q   <= ls_oper_d;
         ls_addr_q   <= ls_addr_d;
         ls_data_q   <= ls_data_d;
         ls_size_q   <= ls_size_d;
         out_valid_q <= out_valid_d;
         out_tag_q   <= out_tag_d;
         out_data_q  <= out_data_d;
`ifdef LSU_MISALIGN_CHK_EN
         out_err_q   <= out_err_d;
`endif
      end
   end

   assign en_ls_o     = en_ls_q;
   assign ls_oper_o   = ls_oper_q;
   assign ls_addr_o   = ls_addr_q;
   assign ls_data_o   = ls_data_q;
   assign ls_size_o   = ls_size_q;
   assign out_valid_o = out_valid_q;
   assign out_tag_o   = out_tag_q;
   assign out_data_o  = out_data_q;
   assign count_o     = count_q;
`ifdef LSU_MISALIGN_CHK_EN
   assign out_err_o   = out_err_q;
`endif

endmodule
